// File: rtl/cpu_pkg.sv
// Shared CPU definitions: exception codes, handler entry address and
// the exception sequencer state encoding.
package cpu_pkg;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;

   typedef enum logic [1:0] {
      IDLE,
      FLUSH,
      REDIRECT
   } exc_state_e;

endpackage

// File: rtl/int_sync.sv
// Multi-flop synchronizer for the asynchronous device interrupt lines.
// Ports: clk, reset (async high), hwint (raw lines), hwint_pend (synced).
module int_sync #(
   parameter int SYNC_STAGES = 2,
   parameter int WIDTH       = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] hwint,
   output logic [WIDTH-1:0] hwint_pend
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= hwint;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign hwint_pend = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/exc_sequencer.sv
// Exception/interrupt entry and ERET sequencer between M stage and CP0.
// Inputs: M-stage instr info (m_*), hwint, CP0 SR/EPC. Outputs: CP0
// update strobes (cp0_*), hwint_pend, flush/stall, redirect, busy.
// Optional: EXC_SEQ_STATS_EN adds exc_count/eret_count saturating counters.
module exc_sequencer
   import cpu_pkg::*;
#(
   parameter logic [31:0] HANDLER_PC   = HANDLER_PC_DEF,
   parameter int          FLUSH_CYCLES = 2,
   parameter int          SYNC_STAGES  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m_valid,
   input  logic [31:0] m_pc,
   input  logic        m_bd,
   input  logic [4:0]  m_exccode,
   input  logic        m_eret,
   input  logic [5:0]  hwint,
   input  logic [5:0]  sr_im,
   input  logic        sr_ie,
   input  logic        sr_exl,
   input  logic [31:0] cp0_epc,
   output logic        cp0_exl_set,
   output logic        cp0_exl_clr,
   output logic [4:0]  cp0_exccode,
   output logic [31:0] cp0_epc_pc,
   output logic        cp0_bd,
   output logic [5:0]  hwint_pend,
   output logic        flush,
   output logic        stall,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
`ifdef EXC_SEQ_STATS_EN
   output logic [15:0] exc_count,
   output logic [15:0] eret_count,
`endif
   output logic        busy
);

   localparam logic [3:0]  CNT_INIT = 4'(FLUSH_CYCLES - 1);
   localparam logic [31:0] WORD_MSK = 32'hFFFF_FFFC;

   exc_state_e  state_q;
   logic [3:0]  cnt_q;
   logic [31:0] target_q;

   logic idle, exc, irq, ert, enter, leave;
   logic [31:0] epc_calc;

   int_sync #(
      .SYNC_STAGES(SYNC_STAGES),
      .WIDTH      (6)
   ) u_sync (
      .clk       (clk),
      .reset     (reset),
      .hwint     (hwint),
      .hwint_pend(hwint_pend)
   );

   // Decisions only in IDLE; reset also masks them so outputs drop at once.
   assign idle  = (state_q == IDLE) & ~reset;
   assign exc   = m_valid & (m_exccode != EXC_INT) & ~sr_exl;
   assign irq   = m_valid & (|(hwint_pend & sr_im)) & sr_ie & ~sr_exl;
   assign ert   = m_valid & m_eret;
   assign enter = idle & (exc | irq);
   assign leave = idle & ert & ~exc & ~irq;

   // A delay-slot instruction restarts at its branch.
   assign epc_calc = (m_pc & WORD_MSK) - (m_bd ? 32'd4 : 32'd0);

   assign cp0_exl_set    = enter;
   assign cp0_exl_clr    = leave;
   assign cp0_exccode    = (enter & exc) ? m_exccode : EXC_INT;
   assign cp0_bd         = enter & m_bd;
   assign cp0_epc_pc     = enter ? epc_calc : 32'd0;
   assign flush          = enter | leave | (state_q == FLUSH);
   assign stall          = (state_q != IDLE);
   assign redirect_valid = (state_q == REDIRECT);
   assign redirect_pc    = target_q;
   assign busy           = (state_q != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         target_q <= HANDLER_PC;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (enter) begin
                  target_q <= HANDLER_PC;
                  cnt_q    <= CNT_INIT;
                  state_q  <= FLUSH;
               end else if (leave) begin
                  target_q <= cp0_epc & WORD_MSK;
                  cnt_q    <= CNT_INIT;
                  state_q  <= FLUSH;
               end
            end
            FLUSH: begin
               if (cnt_q == 4'd0) begin
                  state_q <= REDIRECT;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            REDIRECT: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

`ifdef EXC_SEQ_STATS_EN
   logic [15:0] exc_cnt_q;
   logic [15:0] eret_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         exc_cnt_q  <= 16'd0;
         eret_cnt_q <= 16'd0;
      end else begin
         if (enter && exc_cnt_q != 16'hFFFF) begin
            exc_cnt_q <= exc_cnt_q + 16'd1;
         end
         if (leave && eret_cnt_q != 16'hFFFF) begin
            eret_cnt_q <= eret_cnt_q + 16'd1;
         end
      end
   end

   assign exc_count  = exc_cnt_q;
   assign eret_count = eret_cnt_q;
`endif

endmodule

// File: tb/tb_exc_sequencer.sv
// Randomized self-checking bench for exc_sequencer against a
// sequence-position reference model.
module tb_exc_sequencer;

   localparam int          FC  = 2;
   localparam int          SS  = 2;
   localparam logic [31:0] HPC = 32'h0000_4180;

   logic        clk = 1'b0;
   logic        reset;
   logic        m_valid;
   logic [31:0] m_pc;
   logic        m_bd;
   logic [4:0]  m_exccode;
   logic        m_eret;
   logic [5:0]  hwint;
   logic [5:0]  sr_im;
   logic        sr_ie;
   logic        sr_exl;
   logic [31:0] cp0_epc;
   logic        cp0_exl_set;
   logic        cp0_exl_clr;
   logic [4:0]  cp0_exccode;
   logic [31:0] cp0_epc_pc;
   logic        cp0_bd;
   logic [5:0]  hwint_pend;
   logic        flush;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        busy;
`ifdef EXC_SEQ_STATS_EN
   logic [15:0] exc_count;
   logic [15:0] eret_count;
`endif

   exc_sequencer #(
      .HANDLER_PC  (HPC),
      .FLUSH_CYCLES(FC),
      .SYNC_STAGES (SS)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .m_valid       (m_valid),
      .m_pc          (m_pc),
      .m_bd          (m_bd),
      .m_exccode     (m_exccode),
      .m_eret        (m_eret),
      .hwint         (hwint),
      .sr_im         (sr_im),
      .sr_ie         (sr_ie),
      .sr_exl        (sr_exl),
      .cp0_epc       (cp0_epc),
      .cp0_exl_set   (cp0_exl_set),
      .cp0_exl_clr   (cp0_exl_clr),
      .cp0_exccode   (cp0_exccode),
      .cp0_epc_pc    (cp0_epc_pc),
      .cp0_bd        (cp0_bd),
      .hwint_pend    (hwint_pend),
      .flush         (flush),
      .stall         (stall),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
`ifdef EXC_SEQ_STATS_EN
      .exc_count     (exc_count),
      .eret_count    (eret_count),
`endif
      .busy          (busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: position in the sequence (0 = idle, 1..FC flush,
   // FC+1 redirect), history of sampled hwint, expected target.
   int          pos;
   logic [5:0]  hist [3];
   logic [31:0] exp_tgt;
   int          n_exc;
   int          n_eret;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      pos     = 0;
      exp_tgt = HPC;
      n_exc   = 0;
      n_eret  = 0;
      for (int k = 0; k < 3; k++) hist[k] = 6'd0;
   endtask

   task automatic idle_inputs();
      m_valid   = 1'b0;
      m_pc      = 32'd0;
      m_bd      = 1'b0;
      m_exccode = 5'd0;
      m_eret    = 1'b0;
      hwint     = 6'd0;
      sr_im     = 6'd0;
      sr_ie     = 1'b0;
      sr_exl    = 1'b0;
      cp0_epc   = 32'd0;
   endtask

   // One clock: check outputs at negedge, then advance the model.
   task automatic step();
      logic [5:0]  pend;
      logic        e, i, r, ent, lv;
      logic [31:0] epc;
      @(negedge clk);
      pend = hist[SS-1];
      e    = m_valid && m_exccode != 5'd0 && !sr_exl;
      i    = m_valid && ((pend & sr_im) != 6'd0) && sr_ie && !sr_exl;
      r    = m_valid && m_eret;
      ent  = (pos == 0) && (e || i);
      lv   = (pos == 0) && r && !ent;
      epc  = {m_pc[31:2], 2'b00} - (m_bd ? 32'd4 : 32'd0);
      check("hwint_pend", {26'd0, hwint_pend}, {26'd0, pend});
      check("exl_set", {31'd0, cp0_exl_set}, {31'd0, ent});
      check("exl_clr", {31'd0, cp0_exl_clr}, {31'd0, lv});
      check("exccode", {27'd0, cp0_exccode},
            {27'd0, (ent && e) ? m_exccode : 5'd0});
      check("epc_pc", cp0_epc_pc, ent ? epc : 32'd0);
      check("bd", {31'd0, cp0_bd}, {31'd0, ent && m_bd});
      check("flush", {31'd0, flush},
            {31'd0, ent || lv || (pos >= 1 && pos <= FC)});
      check("stall", {31'd0, stall}, {31'd0, pos != 0});
      check("redirect_valid", {31'd0, redirect_valid},
            {31'd0, pos == FC + 1});
      check("redirect_pc", redirect_pc, exp_tgt);
      check("busy", {31'd0, busy}, {31'd0, pos != 0});
`ifdef EXC_SEQ_STATS_EN
      check("exc_count", {16'd0, exc_count},
            (n_exc > 65535) ? 32'd65535 : 32'(n_exc));
      check("eret_count", {16'd0, eret_count},
            (n_eret > 65535) ? 32'd65535 : 32'(n_eret));
`endif
      @(posedge clk);
      for (int k = 2; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = hwint;
      if (ent) begin
         exp_tgt = HPC;
         pos     = 1;
         n_exc++;
      end else if (lv) begin
         exp_tgt = {cp0_epc[31:2], 2'b00};
         pos     = 1;
         n_eret++;
      end else if (pos != 0) begin
         pos = (pos == FC + 1) ? 0 : pos + 1;
      end
      #1;
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      logic [4:0] codes [4];
      codes[0] = 5'd4;
      codes[1] = 5'd5;
      codes[2] = 5'd10;
      codes[3] = 5'd12;

      idle_inputs();
      reset = 1'b1;
      model_reset();
      #2;
      check("rst_flush", {31'd0, flush}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_redirect_pc", redirect_pc, HPC);
      check("rst_epc_pc", cp0_epc_pc, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      steps(2);

      // Overflow exception, not in a delay slot.
      m_valid = 1'b1; m_exccode = 5'd12; m_pc = 32'h3010;
      step();
      m_valid = 1'b0; m_exccode = 5'd0;
      steps(4);

      // Interrupt on a delay-slot instruction.
      hwint = 6'b000100; sr_im = 6'b000100; sr_ie = 1'b1;
      m_valid = 1'b1; m_pc = 32'h3024; m_bd = 1'b1;
      steps(SS + 1);
      m_valid = 1'b0;
      steps(5);

      // Pending interrupt held off by bubbles.
      steps(3);
      m_valid = 1'b1;
      step();
      m_valid = 1'b0;
      steps(4);

      // Exception beats interrupt and ERET.
      m_valid = 1'b1; m_exccode = 5'd10; m_eret = 1'b1;
      step();
      m_valid = 1'b0; m_exccode = 5'd0; m_eret = 1'b0;
      hwint = 6'd0;
      steps(4 + SS);

      // ERET under EXL, then ERET with a masked exception.
      sr_exl = 1'b1; cp0_epc = 32'h3020; m_valid = 1'b1; m_eret = 1'b1;
      step();
      m_valid = 1'b0;
      steps(4);
      m_valid = 1'b1; m_exccode = 5'd4;
      step();
      m_valid = 1'b0; m_exccode = 5'd0; m_eret = 1'b0; sr_exl = 1'b0;
      steps(4);

      // EPC wraps below zero.
      m_valid = 1'b1; m_exccode = 5'd5; m_pc = 32'd0; m_bd = 1'b1;
      step();
      m_valid = 1'b0; m_exccode = 5'd0; m_bd = 1'b0;
      steps(4);

      // Reset in the second flush cycle aborts the sequence.
      m_valid = 1'b1; m_exccode = 5'd12; m_pc = 32'h3100;
      step();
      m_valid = 1'b0; m_exccode = 5'd0;
      step();
      reset = 1'b1;
      #1;
      check("abort_flush", {31'd0, flush}, 32'd0);
      check("abort_stall", {31'd0, stall}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_redirect", {31'd0, redirect_valid}, 32'd0);
      check("abort_redirect_pc", redirect_pc, HPC);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      steps(4);
      m_valid = 1'b1; m_exccode = 5'd10; m_pc = 32'h3200;
      step();
      m_valid = 1'b0; m_exccode = 5'd0;
      steps(4);

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         m_valid   = ($urandom_range(0, 3) != 0);
         m_pc      = $urandom;
         m_bd      = $urandom_range(0, 1) == 1;
         m_exccode = ($urandom_range(0, 5) == 0) ?
                     codes[$urandom_range(0, 3)] : 5'd0;
         m_eret    = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 7) == 0) hwint = 6'($urandom);
         sr_im     = 6'($urandom);
         sr_ie     = $urandom_range(0, 1) == 1;
         sr_exl    = ($urandom_range(0, 3) == 0);
         cp0_epc   = $urandom;
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
